rx_pkt_gen_sched: RTL and testbench

RX_PKT_GEN_SCHED -- requirements
Module: rx_pkt_gen_sched

---
 rtl/rx_pkt_gen_sched_if.sv | 18 +
 rtl/rx_pkt_gen_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_rx_pkt_gen_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_pkt_gen_sched_if.sv
// ---------------------------------------------------------------------------
// rx_pkt_gen_sched_if
// Load bus between the packet scheduler and the RX packet generator.
//   gen_en          : one-cycle load pulse
//   gen_addr_offset : packet start qwd address, valid from gen_en until the
//                     next load
//   gen_read_cnt    : packet qwd count minus 1, same validity as the address
// master : scheduler side (drives the load)
// slave  : generator side (consumes the load)
// ---------------------------------------------------------------------------
interface rx_pkt_gen_sched_if;
   logic        gen_en;
   logic [63:0] gen_addr_offset;
   logic [10:0] gen_read_cnt;

   modport master (output gen_en, gen_addr_offset, gen_read_cnt);
   modport slave  (input  gen_en, gen_addr_offset, gen_read_cnt);
endinterface

// File: rtl/rx_pkt_gen_sched.sv
// ---------------------------------------------------------------------------
// rx_pkt_gen_sched
// Walks a register table of packet descriptors and issues one generator load
// per packet. Each packet occupies the generator for (cnt+1)*cpq + FIXED_LAT
// cycles. cpq is the clocks per qwd for the link speed captured at start. An
// optional inter-packet gap follows. The table is replayed loop_cnt times,
// or until stop when loop_cnt is 0.
//
// Ports
//   x_clk, reset          : clock, synchronous active-high reset
//   fmac_speed            : 000=10G 101=5G 010=2.5G 001=1G, others reserved
//   cfg_wr/idx/offset/cnt : descriptor table write port (any state)
//   num_desc              : active descriptors minus 1 (sampled at start)
//   loop_cnt              : table passes, 0 = endless (sampled at start)
//   ipg_cyc               : idle cycles after each packet (sampled at start)
//   start, stop           : sequence control pulses
//   gen                   : generator load bus (master)
//   busy                  : not IDLE
//   done                  : one-cycle pulse at sequence end
//   err                   : one-cycle pulse on start with a reserved speed
//   cur_desc              : descriptor currently playing
//   pkt_cnt               : packets launched since start, saturating
// ---------------------------------------------------------------------------
module rx_pkt_gen_sched #(
   parameter int  NDESC     = 8,
   parameter int  FIXED_LAT = 3,
   localparam int IW        = $clog2(NDESC)
) (
   input  logic               x_clk,
   input  logic               reset,
   input  logic [2:0]         fmac_speed,
   input  logic               cfg_wr,
   input  logic [IW-1:0]      cfg_idx,
   input  logic [10:0]        cfg_offset,
   input  logic [10:0]        cfg_cnt,
   input  logic [IW-1:0]      num_desc,
   input  logic [7:0]         loop_cnt,
   input  logic [7:0]         ipg_cyc,
   input  logic               start,
   input  logic               stop,
   rx_pkt_gen_sched_if.master gen,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [IW-1:0]      cur_desc,
   output logic [15:0]        pkt_cnt
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_PLAY = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   // Speed code is legal only for the four defined link rates.
   function automatic logic spd_legal(input logic [2:0] s);
      return (s == 3'b000) || (s == 3'b101) || (s == 3'b010) || (s == 3'b001);
   endfunction

   // cpq = 1 << shift: 10G=1, 5G=2, 2.5G=4, 1G=8.
   function automatic logic [1:0] spd_shift(input logic [2:0] s);
      case (s)
         3'b101:  return 2'd1;
         3'b010:  return 2'd2;
         3'b001:  return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // PLAY down-counter preload: duration minus one. Worst case
   // 2048*8 + FIXED_LAT stays well inside 15 bits.
   function automatic logic [14:0] play_len(input logic [10:0] c, input logic [1:0] sh);
      logic [14:0] n;
      n = ({4'b0, c} + 15'd1) << sh;
      return n + 15'(FIXED_LAT) - 15'd1;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Descriptor table: plain registers, deliberately outside reset.
   logic [10:0] offset_tab [NDESC];
   logic [10:0] cnt_tab    [NDESC];

   always_ff @(posedge x_clk) begin
      if (cfg_wr) begin
         offset_tab[cfg_idx] <= cfg_offset;
         cnt_tab[cfg_idx]    <= cfg_cnt;
      end
   end

   logic [2:0]    state;
   logic [IW-1:0] num_desc_q;
   logic [7:0]    loop_q;
   logic [7:0]    ipg_q;
   logic [1:0]    shift_q;
   logic [7:0]    pass_q;
   logic          stop_q;
   logic [14:0]   play_q;
   logic [7:0]    gap_q;
   logic [IW-1:0] cur_desc_q;
   logic [15:0]   pkt_cnt_q;
   logic          gen_en_q;
   logic [10:0]   offs_q;
   logic [10:0]   cnt_q;
   logic          err_q;

   logic          last_desc;
   logic [7:0]    pass_nxt;
   logic [IW-1:0] nxt_desc;
   logic          seq_end;
   logic          pkt_end;

   // pkt_end marks the final cycle of a packet (end of PLAY when there is no
   // gap, otherwise end of GAP). A stop arriving in that very cycle still
   // counts, so the raw pulse is OR-ed with the latch.
   always_comb begin
      last_desc = (cur_desc_q == num_desc_q);
      pass_nxt  = pass_q + 8'd1;
      nxt_desc  = last_desc ? '0 : cur_desc_q + IW'(1);
      seq_end   = stop_q || stop ||
                  (last_desc && (loop_q != 8'd0) && (pass_nxt == loop_q));
      pkt_end   = ((state == S_PLAY) && (play_q == 15'd0) && (ipg_q == 8'd0)) ||
                  ((state == S_GAP) && (gap_q == 8'd0));
   end

   // Generator fields are captured on the edge that enters LOAD, so a table
   // write landing during LOAD cannot disturb the packet being launched.
   always_ff @(posedge x_clk) begin
      if (reset) begin
         state      <= S_IDLE;
         num_desc_q <= '0;
         loop_q     <= '0;
         ipg_q      <= '0;
         shift_q    <= '0;
         pass_q     <= '0;
         stop_q     <= 1'b0;
         play_q     <= '0;
         gap_q      <= '0;
         cur_desc_q <= '0;
         pkt_cnt_q  <= '0;
         gen_en_q   <= 1'b0;
         offs_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         gen_en_q <= 1'b0;
         err_q    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !stop) begin
                  if (spd_legal(fmac_speed)) begin
                     num_desc_q <= num_desc;
                     loop_q     <= loop_cnt;
                     ipg_q      <= ipg_cyc;
                     shift_q    <= spd_shift(fmac_speed);
                     pass_q     <= '0;
                     stop_q     <= 1'b0;
                     cur_desc_q <= '0;
                     pkt_cnt_q  <= 16'd1;
                     gen_en_q   <= 1'b1;
                     offs_q     <= offset_tab[0];
                     cnt_q      <= cnt_tab[0];
                     state      <= S_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               stop_q <= stop_q | stop;
               play_q <= play_len(cnt_q, shift_q);
               state  <= S_PLAY;
            end
            S_PLAY: begin
               stop_q <= stop_q | stop;
               if (play_q != 15'd0) begin
                  play_q <= play_q - 15'd1;
               end else if (ipg_q != 8'd0) begin
                  gap_q <= ipg_q - 8'd1;
                  state <= S_GAP;
               end
            end
            S_GAP: begin
               stop_q <= stop_q | stop;
               if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;
            end
            S_FIN: begin
               stop_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Packet boundary: finish the sequence or launch the next descriptor.
         if (pkt_end) begin
            if (seq_end) begin
               state <= S_FIN;
            end else begin
               if (last_desc) pass_q <= pass_nxt;
               cur_desc_q <= nxt_desc;
               gen_en_q   <= 1'b1;
               offs_q     <= offset_tab[nxt_desc];
               cnt_q      <= cnt_tab[nxt_desc];
               pkt_cnt_q  <= sat_inc(pkt_cnt_q);
               state      <= S_LOAD;
            end
         end
      end
   end

   assign gen.gen_en          = gen_en_q;
   assign gen.gen_addr_offset = {53'b0, offs_q};
   assign gen.gen_read_cnt    = cnt_q;
   assign busy                = (state != S_IDLE);
   assign done                = (state == S_FIN);
   assign err                 = err_q;
   assign cur_desc            = cur_desc_q;
   assign pkt_cnt             = pkt_cnt_q;

endmodule

// File: tb/tb_rx_pkt_gen_sched.sv
// ---------------------------------------------------------------------------
// tb_rx_pkt_gen_sched
// Directed bench for rx_pkt_gen_sched: reset state, single packet at 10G,
// two-pass table at 1G with gaps, endless loop with stop at 5G, reserved
// speed, reset mid-PLAY, and a maximum-length packet with start held high.
// ---------------------------------------------------------------------------
module tb_rx_pkt_gen_sched;
   localparam int NDESC = 8;
   localparam int IW    = 3;

   logic          x_clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    fmac_speed = 3'b000;
   logic          cfg_wr = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [10:0]   cfg_offset = '0;
   logic [10:0]   cfg_cnt = '0;
   logic [IW-1:0] num_desc = '0;
   logic [7:0]    loop_cnt = '0;
   logic [7:0]    ipg_cyc = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          busy, done, err;
   logic [IW-1:0] cur_desc;
   logic [15:0]   pkt_cnt;

   rx_pkt_gen_sched_if gif ();

   rx_pkt_gen_sched #(.NDESC(NDESC), .FIXED_LAT(3)) dut (
      .x_clk      (x_clk),
      .reset      (reset),
      .fmac_speed (fmac_speed),
      .cfg_wr     (cfg_wr),
      .cfg_idx    (cfg_idx),
      .cfg_offset (cfg_offset),
      .cfg_cnt    (cfg_cnt),
      .num_desc   (num_desc),
      .loop_cnt   (loop_cnt),
      .ipg_cyc    (ipg_cyc),
      .start      (start),
      .stop       (stop),
      .gen        (gif.master),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .cur_desc   (cur_desc),
      .pkt_cnt    (pkt_cnt)
   );

   always #5 x_clk = ~x_clk;

   int cyc = 0;
   always @(posedge x_clk) cyc <= cyc + 1;

   // Event log of generator loads and done pulses, sampled on the falling edge.
   int          en_t[$];
   logic [63:0] en_off[$];
   logic [10:0] en_cnt[$];
   int          done_t[$];
   logic        prev_en = 1'b0;
   int          dbl_en = 0;

   always @(negedge x_clk) begin
      if (gif.gen_en === 1'b1) begin
         en_t.push_back(cyc);
         en_off.push_back(gif.gen_addr_offset);
         en_cnt.push_back(gif.gen_read_cnt);
         if (prev_en) dbl_en++;
      end
      prev_en = (gif.gen_en === 1'b1);
      if (done === 1'b1) done_t.push_back(cyc);
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge x_clk);
      #1;
   endtask

   task automatic wr(input int idx, input int off, input int cnt);
      cfg_wr = 1'b1; cfg_idx = IW'(idx); cfg_offset = 11'(off); cfg_cnt = 11'(cnt);
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic clr();
      en_t.delete(); en_off.delete(); en_cnt.delete(); done_t.delete();
   endtask

   task automatic wait_done(input string tag, input int max);
      int i = 0;
      while (done !== 1'b1 && i < max) begin
         tick();
         i++;
      end
      chk(tag, done, 1'b1);
   endtask

   int t0;

   initial begin
      // Reset state
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_gen_en", gif.gen_en, 0);
      chk("rst_offset", gif.gen_addr_offset, 0);
      chk("rst_rdcnt", gif.gen_read_cnt, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_cur_desc", cur_desc, 0);

      // Single packet at 10G: 1 + 7 + 3 + 1 cycles to done
      wr(0, 'h000, 6);
      fmac_speed = 3'b000; num_desc = 0; loop_cnt = 1; ipg_cyc = 0;
      clr();
      t0 = cyc; start = 1'b1; tick(); start = 1'b0;
      chk("t1_busy", busy, 1);
      wait_done("t1_done_timeout", 100);
      chk("t1_done_lat", done_t.size() > 0 ? done_t[0] - t0 : -1, 12);
      chk("t1_en_num", en_t.size(), 1);
      chk("t1_offset", en_off.size() > 0 ? en_off[0] : 64'hdead, 0);
      chk("t1_rdcnt", en_cnt.size() > 0 ? en_cnt[0] : 11'h7ff, 6);
      chk("t1_pkt_cnt", pkt_cnt, 1);
      tick();
      chk("t1_idle", busy, 0);
      chk("t1_done_once", done, 0);

      // Two descriptors, two passes, 1G, ipg 4
      wr(0, 'h010, 3);
      wr(1, 'h020, 1);
      fmac_speed = 3'b001; num_desc = 1; loop_cnt = 2; ipg_cyc = 4;
      clr();
      start = 1'b1; tick(); start = 1'b0;
      wait_done("t2_done_timeout", 500);
      chk("t2_en_num", en_t.size(), 4);
      if (en_t.size() == 4) begin
         chk("t2_off0", en_off[0], 'h010);
         chk("t2_off1", en_off[1], 'h020);
         chk("t2_off2", en_off[2], 'h010);
         chk("t2_off3", en_off[3], 'h020);
         chk("t2_cnt0", en_cnt[0], 3);
         chk("t2_gap01", en_t[1] - en_t[0], 40);
         chk("t2_gap12", en_t[2] - en_t[1], 24);
         chk("t2_gap23", en_t[3] - en_t[2], 40);
      end
      chk("t2_pkt_cnt", pkt_cnt, 4);
      tick();
      chk("t2_done_num", done_t.size(), 1);
      chk("t2_idle", busy, 0);

      // Endless loop at 5G, stop during PLAY of descriptor 2
      wr(2, 'h030, 5);
      fmac_speed = 3'b101; num_desc = 2; loop_cnt = 0; ipg_cyc = 2;
      clr();
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 300 && en_t.size() < 3; i++) tick();
      chk("t3_third_load", en_t.size(), 3);
      chk("t3_cur_desc", cur_desc, 2);
      repeat (3) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      wait_done("t3_done_timeout", 100);
      // desc 2: PLAY 6*2+3 = 15, GAP 2, FIN one cycle later
      chk("t3_done_lat", (en_t.size() == 3 && done_t.size() > 0) ? done_t[0] - en_t[2] : -1, 18);
      chk("t3_off2", en_t.size() == 3 ? en_off[2] : 64'hdead, 'h030);
      chk("t3_pkt_cnt", pkt_cnt, 3);
      repeat (5) tick();
      chk("t3_no_more_load", en_t.size(), 3);
      chk("t3_done_num", done_t.size(), 1);
      chk("t3_idle", busy, 0);

      // Reserved speed, then start with stop in the same cycle
      clr();
      fmac_speed = 3'b011; start = 1'b1; tick(); start = 1'b0;
      chk("t4_err", err, 1);
      chk("t4_busy", busy, 0);
      tick();
      chk("t4_err_pulse", err, 0);
      chk("t4_no_load", en_t.size(), 0);
      fmac_speed = 3'b000; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      tick();
      chk("t4_startstop_busy", busy, 0);
      chk("t4_startstop_load", en_t.size(), 0);

      // Reset mid-PLAY, table must survive
      fmac_speed = 3'b001; num_desc = 0; loop_cnt = 1; ipg_cyc = 0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      chk("t5_playing", busy, 1);
      clr();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_gen_en", gif.gen_en, 0);
      chk("t5_offset", gif.gen_addr_offset, 0);
      chk("t5_rdcnt", gif.gen_read_cnt, 0);
      chk("t5_pkt_cnt", pkt_cnt, 0);
      chk("t5_cur_desc", cur_desc, 0);
      repeat (40) tick();
      chk("t5_no_done", done_t.size(), 0);
      fmac_speed = 3'b000;
      start = 1'b1; tick(); start = 1'b0;
      chk("t5_tab_off", gif.gen_addr_offset, 'h010);
      chk("t5_tab_cnt", gif.gen_read_cnt, 3);
      wait_done("t5_done_timeout", 100);
      tick();

      // Max-length packet at 1G with start held high throughout
      wr(0, 'h100, 2047);
      fmac_speed = 3'b001; num_desc = 0; loop_cnt = 1; ipg_cyc = 0;
      clr();
      start = 1'b1; tick();
      fmac_speed = 3'b000;
      wait_done("t6_done_timeout", 17000);
      start = 1'b0;
      chk("t6_en_num", en_t.size(), 1);
      chk("t6_play_len", (en_t.size() > 0 && done_t.size() > 0) ? done_t[0] - en_t[0] - 1 : -1, 16387);
      chk("t6_pkt_cnt", pkt_cnt, 1);
      repeat (3) tick();
      chk("t6_idle", busy, 0);
      chk("t6_single_seq", en_t.size(), 1);
      chk("gen_en_back_to_back", dbl_en, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
